// File: rtl/dmem_responder.sv
// Data-memory responder for ME-stage load/store requests.
// Word RAM with byte enables, fixed wait states and a valid/ready response.
module dmem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;
    logic        busy_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH];

    logic              addr_err;
    logic [ADDR_W-1:0] widx;
    logic              fire;
    logic              wr_en;

    assign addr_err = (addr_q[1:0] != 2'b00)
                   || (addr_q[31:ADDR_W+2] != '0);
    assign widx     = addr_q[ADDR_W+1:2];
    assign fire     = (state_q == WAIT) && (cnt_q == 4'd0);
    // Gated by reset so a store caught mid-flight never lands.
    assign wr_en    = fire && we_q && !addr_err && reset_0;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                    if (req_valid && ready_q) begin
                        we_q    <= req_we;
                        be_q    <= req_be;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= 4'(WAIT_CYC);
                        state_q <= WAIT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        err_q   <= addr_err;
                        rdata_q <= (addr_err || we_q) ? 32'd0 : mem[widx];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed stores/loads,
// byte enables, errors, backpressure and reset during a store.
module tb_dmem_responder;

    localparam int ADDR_W   = 10;
    localparam int WAIT_CYC = 2;
    localparam int LAT      = WAIT_CYC + 1;

    logic        clock = 1'b0;
    logic        reset_0 = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    dmem_responder #(
        .ADDR_W  (ADDR_W),
        .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clock     (clock),
        .reset_0   (reset_0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic prev_v = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of resp_valid, data on handshake.
    always @(negedge clock) begin
        if (!reset_0) begin
            prev_v = 1'b0;
        end else begin
            if (resp_valid && !prev_v) begin
                if (sb.size() == 0)
                    check("unexpected resp", 32'd1, 32'd0);
                else
                    check("latency", 32'(cyc - sb[0].acc), 32'(LAT));
            end
            if (resp_valid && resp_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", resp_rdata, e.rdata);
                check("err", 32'(resp_err), 32'(e.err));
            end
            prev_v = resp_valid;
        end
    end

    task automatic do_req(input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit track);
        int t;
        t = 0;
        @(negedge clock);
        while (!req_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("req_ready wait", 32'(req_ready), 32'd1);
        if (!req_ready) return;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        if (track) sb.push_back('{exp_rd, exp_err, cyc});
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hA5A5_A5A5;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd0);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_rdata"}, resp_rdata, 32'd0);
        check({tag, " resp_err"}, 32'(resp_err), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_0 = 1'b1;
        @(posedge clock);
        #1;
        check("ready after reset", 32'(req_ready), 32'd1);

        do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1);
        do_req(1'b0, 4'h0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1);

        do_req(1'b1, 4'hF, 32'h20, 32'h11223344, 32'd0, 1'b0, 1);
        do_req(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'd0, 1'b0, 1);
        do_req(1'b0, 4'h0, 32'h20, 32'd0, 32'h11BB33DD, 1'b0, 1);

        do_req(1'b0, 4'h0, 32'h22, 32'd0, 32'd0, 1'b1, 1);
        do_req(1'b1, 4'hF, 32'h0, 32'h55555555, 32'd0, 1'b0, 1);
        do_req(1'b1, 4'hF, 32'h1000, 32'h99999999, 32'd0, 1'b1, 1);
        do_req(1'b0, 4'h0, 32'h0, 32'd0, 32'h55555555, 1'b0, 1);
        do_req(1'b1, 4'hF, 32'h3, 32'h77777777, 32'd0, 1'b1, 1);
        do_req(1'b0, 4'h0, 32'h0, 32'd0, 32'h55555555, 1'b0, 1);

        do_req(1'b1, 4'h0, 32'h10, 32'h0, 32'd0, 1'b0, 1);
        do_req(1'b0, 4'h0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1);
        drain();

        // Backpressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        do_req(1'b0, 4'h0, 32'h20, 32'd0, 32'h11BB33DD, 1'b0, 1);
        begin
            int t;
            t = 0;
            while (!resp_valid && t < 50) begin
                @(negedge clock);
                t++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp resp_valid", 32'(resp_valid), 32'd1);
            check("bp rdata", resp_rdata, 32'h11BB33DD);
            check("bp req_ready", 32'(req_ready), 32'd0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        drain();

        do_req(1'b1, 4'hF, 32'h30, 32'h12345678, 32'd0, 1'b0, 1);
        drain();
        do_req(1'b1, 4'hF, 32'h30, 32'hFFFFFFFF, 32'd0, 1'b0, 0);
        check("busy in wait", 32'(busy), 32'd1);
        reset_0 = 1'b0;
        #1;
        check_all_zero("midop");
        repeat (4) @(negedge clock);
        check_all_zero("midop hold");
        reset_0 = 1'b1;
        do_req(1'b0, 4'h0, 32'h30, 32'd0, 32'h12345678, 1'b0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
